// File: rtl/fault_diff_collector_pkg.sv
// fault_diff_collector_pkg: shared state enum, default width and popcount width helper.
package fault_diff_collector_pkg;
  localparam int DATA_W_DEF = 128;
  typedef enum logic [1:0] {IDLE, HAVE_GOLD, CALC, HOLD} state_t;
  function automatic int pop_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/fault_diff_collector_popcount.sv
// popcount: combinational count of set bits in a DATA_W-wide word.
module popcount
  import fault_diff_collector_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0]        i_data,
  output logic [pop_w(DATA_W)-1:0] o_cnt
);
  localparam int PW = pop_w(DATA_W);
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < DATA_W; i++) o_cnt = o_cnt + PW'(i_data[i]);
  end
endmodule

// File: rtl/fault_diff_collector.sv
// fault_diff_collector: pairs golden and faulty ciphertexts at the same fault location
// and emits their XOR difference with byte mask and popcount.
module fault_diff_collector
  import fault_diff_collector_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic                      CLK_50,
  input  logic                      RST_N,
  input  logic                      ct_valid,
  output logic                      ct_ready,
  input  logic [DATA_W-1:0]         ct_data,
  input  logic                      ct_fault,
  input  logic [6:0]                ct_loc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_diff,
  output logic [DATA_W/8-1:0]       out_byte_mask,
  output logic [pop_w(DATA_W)-1:0]  out_popcnt,
  output logic [6:0]                out_loc,
  output logic                      pair_err,
  output logic [CNT_W-1:0]          pair_cnt
);
  localparam int PW = pop_w(DATA_W);
  state_t              r_state, w_next;
  logic                r_live;
  logic [DATA_W-1:0]   r_gold, r_fault;
  logic [6:0]          r_loc;
  logic                w_xfer, w_err, w_ld_gold, w_ld_fault;
  logic [DATA_W-1:0]   w_diff;
  logic [DATA_W/8-1:0] w_mask;
  logic [PW-1:0]       w_pop;

  // r_live keeps ct_ready low while reset is held and until the first edge after release
  assign ct_ready   = r_live && (r_state == IDLE || r_state == HAVE_GOLD);
  assign out_valid  = r_state == HOLD;
  assign w_xfer     = ct_valid && ct_ready;
  assign w_ld_gold  = w_xfer && !ct_fault;
  assign w_ld_fault = w_xfer && ct_fault && r_state == HAVE_GOLD && ct_loc == r_loc;
  assign w_err      = w_xfer && ct_fault && !w_ld_fault;
  assign w_diff     = r_gold ^ r_fault;

  genvar b;
  generate
    for (b = 0; b < DATA_W / 8; b++) begin : g_mask
      assign w_mask[b] = |w_diff[8*b +: 8];
    end
  endgenerate

  popcount #(.DATA_W(DATA_W)) u_pop (.i_data(w_diff), .o_cnt(w_pop));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_ld_gold ? HAVE_GOLD : IDLE;
      HAVE_GOLD: w_next = w_ld_fault ? CALC : HAVE_GOLD;
      CALC:      w_next = HOLD;
      HOLD:      w_next = out_ready ? IDLE : HOLD;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= IDLE;
      r_live        <= 1'b0;
      r_gold        <= '0;
      r_fault       <= '0;
      r_loc         <= '0;
      out_diff      <= '0;
      out_byte_mask <= '0;
      out_popcnt    <= '0;
      out_loc       <= '0;
      pair_err      <= 1'b0;
      pair_cnt      <= '0;
    end else begin
      r_state  <= w_next;
      r_live   <= 1'b1;
      pair_err <= w_err;
      if (w_ld_gold) begin
        r_gold <= ct_data;
        r_loc  <= ct_loc;
      end
      if (w_ld_fault) r_fault <= ct_data;
      if (r_state == CALC) begin
        out_diff      <= w_diff;
        out_byte_mask <= w_mask;
        out_popcnt    <= w_pop;
        out_loc       <= r_loc;
      end
      if (r_state == HOLD && out_ready) pair_cnt <= pair_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fault_diff_collector.sv
// tb_fault_diff_collector: scoreboard bench; stimulus pushes expected records, a monitor pops them.
module tb_fault_diff_collector;
  logic         clk = 0;
  logic         RST_N = 0;
  logic         ct_valid = 0, ct_fault = 0, out_ready = 1;
  logic [127:0] ct_data = '0;
  logic [6:0]   ct_loc = '0;
  logic         ct_ready, out_valid, pair_err;
  logic [127:0] out_diff;
  logic [15:0]  out_byte_mask;
  logic [7:0]   out_popcnt, pair_cnt, exp_cnt;
  logic [6:0]   out_loc;
  int           checks = 0, errors = 0, err_seen = 0, e0;

  typedef struct packed {
    logic [127:0] diff;
    logic [15:0]  mask;
    logic [7:0]   pc;
    logic [6:0]   loc;
  } rec_t;
  rec_t exp_q[$];

  always #5 clk = ~clk;

  fault_diff_collector dut (
    .CLK_50(clk), .RST_N(RST_N), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .ct_data(ct_data), .ct_fault(ct_fault), .ct_loc(ct_loc),
    .out_valid(out_valid), .out_ready(out_ready), .out_diff(out_diff),
    .out_byte_mask(out_byte_mask), .out_popcnt(out_popcnt), .out_loc(out_loc),
    .pair_err(pair_err), .pair_cnt(pair_cnt)
  );

  always @(negedge clk) begin
    if (RST_N) begin
      rec_t e;
      if (pair_err) err_seen++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_record diff=%h loc=%0d", out_diff, out_loc);
        end else begin
          e = exp_q.pop_front();
          if (out_diff !== e.diff || out_byte_mask !== e.mask || out_popcnt !== e.pc || out_loc !== e.loc) begin
            errors++;
            $display("FAIL record got diff=%h mask=%h pc=%0d loc=%0d want diff=%h mask=%h pc=%0d loc=%0d",
                     out_diff, out_byte_mask, out_popcnt, out_loc, e.diff, e.mask, e.pc, e.loc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [127:0] d, input logic f, input logic [6:0] l);
    int n = 0;
    @(negedge clk);
    while (!ct_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_timeout", 128'(ct_ready), 128'(1));
    ct_valid = 1; ct_data = d; ct_fault = f; ct_loc = l;
    @(posedge clk);
    #1 ct_valid = 0;
  endtask

  task automatic pair(input logic [127:0] g, input logic [127:0] dif, input logic [6:0] l,
                      input logic [15:0] m, input logic [7:0] pc);
    send(g, 0, l);
    send(g ^ dif, 1, l);
    exp_q.push_back('{dif, m, pc, l});
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 128'(exp_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_ready", 128'(ct_ready), 128'(0));
    chk("rst_outs", {out_diff}, 128'(0));
    chk("rst_misc", 128'({out_valid, out_byte_mask, out_popcnt, out_loc, pair_err, pair_cnt}), 128'(0));
    repeat (2) @(negedge clk);
    RST_N = 1;
    @(posedge clk);
    #1 chk("ready_after_rst", 128'(ct_ready), 128'(1));
    exp_cnt = 0;

    send(128'h0, 0, 7'd5);
    send(128'h1, 1, 7'd5);
    exp_q.push_back('{128'h1, 16'h0001, 8'd1, 7'd5});
    @(negedge clk);
    chk("lat_n1_invalid", 128'(out_valid), 128'(0));
    @(negedge clk);
    chk("lat_n2_valid", 128'(out_valid), 128'(1));
    drain(); exp_cnt++;
    chk("cnt_after_first", 128'(pair_cnt), 128'(exp_cnt));

    e0 = err_seen;
    send(128'hDEAD, 1, 7'd9);
    repeat (2) @(negedge clk);
    chk("idle_fault_err", 128'(err_seen), 128'(e0 + 1));
    chk("idle_fault_no_valid", 128'(out_valid), 128'(0));
    chk("idle_fault_ready", 128'(ct_ready), 128'(1));

    e0 = err_seen;
    send(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 0, 7'd3);
    send(128'h5555, 1, 7'd4);
    repeat (2) @(negedge clk);
    chk("loc_mismatch_err", 128'(err_seen), 128'(e0 + 1));
    send(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677 ^ 128'h8000_0000_0000_0000_0000_0000_0000_0300, 1, 7'd3);
    exp_q.push_back('{128'h8000_0000_0000_0000_0000_0000_0000_0300, 16'h8002, 8'd3, 7'd3});
    drain(); exp_cnt++;

    e0 = err_seen;
    send(128'hAAAA, 0, 7'd20);
    send(128'h0BAD_F00D, 0, 7'd21);
    send(128'hAAAB, 1, 7'd20);
    send(128'h0BAD_F00D ^ 128'h0000_0001_0000_0000_0000_0000_0000_0000, 1, 7'd21);
    exp_q.push_back('{128'h0000_0001_0000_0000_0000_0000_0000_0000, 16'h1000, 8'd1, 7'd21});
    drain(); exp_cnt++;
    chk("overwrite_err", 128'(err_seen), 128'(e0 + 1));

    pair(128'hCAFE_BABE, 128'h0, 7'd127, 16'h0, 8'd0);
    drain(); exp_cnt++;

    out_ready = 0;
    pair({4{32'h1111_1111}}, 128'h00F0_000F, 7'd10, 16'h0005, 8'd8);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_stable", {out_diff ^ 128'h00F0_000F, 104'(0), ct_ready, out_valid, out_popcnt, out_loc},
          {128'h0, 104'(0), 1'b0, 1'b1, 8'd8, 7'd10});
    end
    @(posedge clk);
    #1 out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0; exp_cnt++;
    chk("hold_release_cnt", 128'(pair_cnt), 128'(exp_cnt));
    chk("hold_release_idle", 128'({out_valid, ct_ready}), 128'(2'b01));
    out_ready = 1;

    pair({128{1'b1}}, {128{1'b1}}, 7'd0, 16'hFFFF, 8'd128);
    drain(); exp_cnt++;
    chk("cnt_before_rst", 128'(pair_cnt), 128'(exp_cnt));

    send(128'h77, 0, 7'd33);
    send(128'h76, 1, 7'd33);
    #1 RST_N = 0;
    #1;
    chk("rst_calc_outs", out_diff, 128'(0));
    chk("rst_calc_misc", 128'({ct_ready, out_valid, out_byte_mask, out_popcnt, out_loc, pair_err, pair_cnt}), 128'(0));
    repeat (2) @(negedge clk);
    RST_N = 1;
    exp_cnt = 0;
    pair(128'h1234, 128'h0100, 7'd44, 16'h0002, 8'd1);
    drain(); exp_cnt++;
    chk("cnt_after_rst_pair", 128'(pair_cnt), 128'(exp_cnt));

    for (int i = 0; i < 255; i++) begin
      pair(128'(i), 128'h3, 7'(i), 16'h0001, 8'd2);
      drain();
    end
    chk("cnt_wrap", 128'(pair_cnt), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
